// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: stall encoding plus the request/CSR/redirect bundle of the trap controller
package trap_ctrl_pkg;
  typedef enum logic [1:0] {NO_STALL = 2'd0, STALL_FETCH = 2'd1, STALL_MEM = 2'd2, STALL_ALL = 2'd3} stall_e;
endpackage

interface trap_ctrl_if #(parameter int XLEN = 32);
  import trap_ctrl_pkg::*;
  stall_e stall_i;
  logic fe_exc_i, de_exc_i, ex_exc_i, mem_exc_i;
  logic [3:0] fe_cause_i, de_cause_i, ex_cause_i, mem_cause_i;
  logic [XLEN-1:0] fe_pc_i, de_pc_i, ex_pc_i, mem_pc_i;
  logic [XLEN-1:0] fe_tval_i, de_tval_i, ex_tval_i, mem_tval_i;
  logic mret_i, mstatus_mie_i;
  logic [XLEN-1:0] int_pc_i, mie_i, mip_i, mtvec_i, mepc_i;
  logic trap_active_o, de_trap_active_o, redirect_o, flush_o, busy_o;
  logic [XLEN-1:0] trap_cause_o, trap_mepc_o, trap_tval_o, redirect_pc_o;
  modport master (
    input stall_i, fe_exc_i, de_exc_i, ex_exc_i, mem_exc_i,
    input fe_cause_i, de_cause_i, ex_cause_i, mem_cause_i,
    input fe_pc_i, de_pc_i, ex_pc_i, mem_pc_i,
    input fe_tval_i, de_tval_i, ex_tval_i, mem_tval_i,
    input mret_i, mstatus_mie_i, int_pc_i, mie_i, mip_i, mtvec_i, mepc_i,
    output trap_active_o, de_trap_active_o, redirect_o, flush_o, busy_o,
    output trap_cause_o, trap_mepc_o, trap_tval_o, redirect_pc_o
  );
  modport slave (
    output stall_i, fe_exc_i, de_exc_i, ex_exc_i, mem_exc_i,
    output fe_cause_i, de_cause_i, ex_cause_i, mem_cause_i,
    output fe_pc_i, de_pc_i, ex_pc_i, mem_pc_i,
    output fe_tval_i, de_tval_i, ex_tval_i, mem_tval_i,
    output mret_i, mstatus_mie_i, int_pc_i, mie_i, mip_i, mtvec_i, mepc_i,
    input trap_active_o, de_trap_active_o, redirect_o, flush_o, busy_o,
    input trap_cause_o, trap_mepc_o, trap_tval_o, redirect_pc_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: selects one trap/mret/interrupt per accept, drives CSR update, redirect and flush drain (TRAP_VECTORED_EN enables vectored interrupts)
module trap_ctrl import trap_ctrl_pkg::*; #(
  parameter int XLEN = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input logic clk_i,
  input logic rst_ni,
  trap_ctrl_if.master bus
);
  localparam int CW = $clog2(FLUSH_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, TRAP, RET, DRAIN} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] pend, epc, etval, base, vec, cause_d, mepc_d, tval_d, rpc_d;
  logic [3:0] icode, ecode;
  logic irq, any_exc, take, ret, is_irq, drain_done, unused;
  assign pend = bus.mip_i & bus.mie_i & XLEN'(12'h888);
  assign irq = bus.mstatus_mie_i & |pend;
  assign icode = pend[11] ? 4'd11 : pend[3] ? 4'd3 : 4'd7;
  assign any_exc = bus.mem_exc_i | bus.ex_exc_i | bus.de_exc_i | bus.fe_exc_i;
  assign take = state_q == IDLE && bus.stall_i == NO_STALL && (any_exc | bus.mret_i | irq);
  assign ret = !bus.mem_exc_i && !bus.ex_exc_i && bus.mret_i;
  assign is_irq = !any_exc && !bus.mret_i;
  assign ecode = bus.mem_exc_i ? bus.mem_cause_i : bus.ex_exc_i ? bus.ex_cause_i : bus.de_exc_i ? bus.de_cause_i : bus.fe_cause_i;
  assign epc = bus.mem_exc_i ? bus.mem_pc_i : bus.ex_exc_i ? bus.ex_pc_i : bus.de_exc_i ? bus.de_pc_i : bus.fe_pc_i;
  assign etval = bus.mem_exc_i ? bus.mem_tval_i : bus.ex_exc_i ? bus.ex_tval_i : bus.de_exc_i ? bus.de_tval_i : bus.fe_tval_i;
  assign cause_d = is_irq ? {1'b1, {(XLEN-5){1'b0}}, icode} : XLEN'(ecode);
  assign mepc_d = is_irq ? bus.int_pc_i : epc;
  assign tval_d = is_irq ? '0 : etval;
  assign base = {bus.mtvec_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
  assign vec = (is_irq && bus.mtvec_i[1:0] == 2'b01) ? base + XLEN'({icode, 2'b00}) : base;
`else
  assign vec = base;
`endif
  assign rpc_d = ret ? {bus.mepc_i[XLEN-1:1], 1'b0} : vec;
  assign drain_done = cnt_q >= CW'(FLUSH_CYCLES - 2);
  assign unused = ^{bus.mtvec_i[1:0], bus.mepc_i[0]};
  // next state and saturating drain counter
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    state_d = state_q == IDLE ? (take ? (ret ? RET : TRAP) : IDLE)
            : state_q == DRAIN ? (drain_done ? IDLE : DRAIN)
            : (FLUSH_CYCLES > 1 ? DRAIN : IDLE);
    cnt_d = state_q == DRAIN ? (cnt_q == '1 ? cnt_q : cnt_q + 1'b1) : '0;
  end
  // state register and registered outputs, derived from the next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bus.trap_active_o <= 1'b0;
      bus.de_trap_active_o <= 1'b0;
      bus.redirect_o <= 1'b0;
      bus.flush_o <= 1'b0;
      bus.busy_o <= 1'b0;
      bus.trap_cause_o <= '0;
      bus.trap_mepc_o <= '0;
      bus.trap_tval_o <= '0;
      bus.redirect_pc_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bus.trap_active_o <= state_d == TRAP && state_q == IDLE;
      bus.de_trap_active_o <= state_d == RET && state_q == IDLE;
      bus.redirect_o <= take;
      bus.flush_o <= state_d != IDLE;
      bus.busy_o <= state_d != IDLE;
      if (take) bus.redirect_pc_o <= rpc_d;
      if (take && !ret) begin
        bus.trap_cause_o <= cause_d;
        bus.trap_mepc_o <= mepc_d;
        bus.trap_tval_o <= tval_d;
      end
    end
  end
endmodule
